rom_port_arbiter: RTL and testbench

Two-requester arbiter in front of the instruction ROM (12-bit byte address, 1024 x 32-bit words, combinational read). Shares the single ROM read port between the instruction-fetch unit (port 0) and a secondary reader, either the data-side constant load path or the debug reader (port 1). Grants at most one access per cycle with round-robin fairness and returns registered read data one cycle after grant. Also flags misaligned addresses and keeps saturating per-port access counters for the performance display.

---
 rtl/rom_port_arbiter.sv | 118 +++++++++++
 tb/tb_rom_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Two-port round-robin arbiter sharing one combinational ROM read port.
// Registered responses one cycle after grant, misalignment flagging, saturating grant counters.
module rom_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_err,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  clr_count,
  output logic [CNT_WIDTH-1:0]  p0_count,
  output logic [CNT_WIDTH-1:0]  p1_count
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  port_e                 last_gnt_q, last_gnt_d;
  logic                  p0_rvalid_q, p1_rvalid_q;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic                  p0_err_q, p0_err_d, p1_err_q, p1_err_d;
  logic [CNT_WIDTH-1:0]  p0_cnt_q, p0_cnt_d, p1_cnt_q, p1_cnt_d;
  logic                  misalign;
  logic [DATA_WIDTH-1:0] resp_data;

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (p0_req && p1_req) begin
      if (last_gnt_q == PORT1) p0_gnt = 1'b1;
      else                     p1_gnt = 1'b1;
    end else begin
      p0_gnt = p0_req;
      p1_gnt = p1_req;
    end
  end

  // Idle cycles still present port 0's address so the fetch path stays warm.
  assign rom_addr  = p1_gnt ? p1_addr : p0_addr;
  assign misalign  = |rom_addr[1:0];
  assign resp_data = misalign ? '0 : rom_data;

  always_comb begin
    last_gnt_d = last_gnt_q;
    p0_rdata_d = p0_rdata_q;
    p0_err_d   = p0_err_q;
    p1_rdata_d = p1_rdata_q;
    p1_err_d   = p1_err_q;
    p0_cnt_d   = p0_cnt_q;
    p1_cnt_d   = p1_cnt_q;
    if (p0_gnt) begin
      last_gnt_d = PORT0;
      p0_rdata_d = resp_data;
      p0_err_d   = misalign;
      if (p0_cnt_q != '1) p0_cnt_d = p0_cnt_q + 1'b1;
    end
    if (p1_gnt) begin
      last_gnt_d = PORT1;
      p1_rdata_d = resp_data;
      p1_err_d   = misalign;
      if (p1_cnt_q != '1) p1_cnt_d = p1_cnt_q + 1'b1;
    end
    if (clr_count) begin
      p0_cnt_d = '0;
      p1_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q  <= PORT1;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      p0_cnt_q    <= '0;
      p1_cnt_q    <= '0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      p0_rvalid_q <= p0_gnt;
      p1_rvalid_q <= p1_gnt;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_err_q    <= p0_err_d;
      p1_err_q    <= p1_err_d;
      p0_cnt_q    <= p0_cnt_d;
      p1_cnt_q    <= p1_cnt_d;
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_err    = p0_err_q;
  assign p1_err    = p1_err_q;
  assign p0_count  = p0_cnt_q;
  assign p1_count  = p1_cnt_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a cycle-level reference model and literal spot checks.
module tb_rom_port_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req = 1'b0, p1_req = 1'b0, clr_count = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata, rom_data;
  logic [AW-1:0] rom_addr;
  logic [CW-1:0] p0_count, p1_count;

  int checks = 0;
  int failures = 0;

  rom_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .rom_addr(rom_addr), .rom_data(rom_data), .clr_count(clr_count),
    .p0_count(p0_count), .p1_count(p1_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input int idx);
    return 32'h2008_0000 + 32'(idx);
  endfunction

  assign rom_data = rom_word(int'(rom_addr >> 2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which port was served most recently, and what each port last received.
  int            m_last;
  bit            m_valid = 1'b0;
  bit            m_rv[2];
  logic [DW-1:0] m_rd[2];
  bit            m_err[2];
  int            m_cnt[2];

  always @(negedge clk) begin
    int winner;
    logic [AW-1:0] addr;
    bit req[2];
    logic [AW-1:0] a[2];
    req[0] = p0_req; req[1] = p1_req;
    a[0] = p0_addr;  a[1] = p1_addr;
    if (req[0] && req[1]) winner = 1 - m_last;
    else if (req[0])      winner = 0;
    else if (req[1])      winner = 1;
    else                  winner = -1;
    addr = (winner == 1) ? a[1] : a[0];
    if (m_valid) begin
      chk("m_p0_gnt", 64'(p0_gnt), 64'(winner == 0));
      chk("m_p1_gnt", 64'(p1_gnt), 64'(winner == 1));
      chk("m_rom_addr", 64'(rom_addr), 64'(addr));
      chk("m_p0_rvalid", 64'(p0_rvalid), 64'(m_rv[0]));
      chk("m_p1_rvalid", 64'(p1_rvalid), 64'(m_rv[1]));
      chk("m_p0_rdata", 64'(p0_rdata), 64'(m_rd[0]));
      chk("m_p1_rdata", 64'(p1_rdata), 64'(m_rd[1]));
      chk("m_p0_err", 64'(p0_err), 64'(m_err[0]));
      chk("m_p1_err", 64'(p1_err), 64'(m_err[1]));
      chk("m_p0_count", 64'(p0_count), 64'(m_cnt[0]));
      chk("m_p1_count", 64'(p1_count), 64'(m_cnt[1]));
    end
    if (rst) begin
      m_valid = 1'b1;
      m_last  = 1;
      for (int p = 0; p < 2; p++) begin
        m_rv[p] = 0; m_rd[p] = '0; m_err[p] = 0; m_cnt[p] = 0;
      end
    end else if (m_valid) begin
      for (int p = 0; p < 2; p++) begin
        m_rv[p] = (winner == p);
        if (winner == p) begin
          m_err[p] = (a[p] % 4) != 0;
          m_rd[p]  = m_err[p] ? '0 : rom_word(int'(a[p]) / 4);
          m_cnt[p] = (m_cnt[p] < CMAX) ? m_cnt[p] + 1 : CMAX;
        end
        if (clr_count) m_cnt[p] = 0;
      end
      if (winner >= 0) m_last = winner;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    next_cycle();
    next_cycle();
    rst = 1'b0;
    at_neg();
    chk("rst_p0_rvalid", 64'(p0_rvalid), 64'd0);
    chk("rst_p1_rvalid", 64'(p1_rvalid), 64'd0);
    chk("rst_p0_rdata", 64'(p0_rdata), 64'd0);
    chk("rst_p0_count", 64'(p0_count), 64'd0);
    chk("rst_p1_count", 64'(p1_count), 64'd0);

    // Single aligned fetch from port 0.
    next_cycle();
    p0_req = 1'b1; p0_addr = 12'h004;
    at_neg();
    chk("t1_p0_gnt", 64'(p0_gnt), 64'd1);
    chk("t1_p1_gnt", 64'(p1_gnt), 64'd0);
    chk("t1_rom_addr", 64'(rom_addr), 64'h004);
    next_cycle();
    p0_req = 1'b0;
    at_neg();
    chk("t1_p0_rvalid", 64'(p0_rvalid), 64'd1);
    chk("t1_p0_rdata", 64'(p0_rdata), 64'h2008_0001);
    chk("t1_p0_err", 64'(p0_err), 64'd0);
    chk("t1_p1_gnt", 64'(p1_gnt), 64'd0);

    // Continuous dual requests straight out of reset alternate P0,P1,...
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; p0_req = 1'b1; p1_req = 1'b1; p0_addr = 12'h010; p1_addr = 12'h020;
    for (int i = 0; i < 6; i++) begin
      at_neg();
      chk("t2_p0_gnt", 64'(p0_gnt), 64'((i % 2) == 0));
      chk("t2_p1_gnt", 64'(p1_gnt), 64'((i % 2) == 1));
      if (i > 0) chk("t2_p0_rvalid", 64'(p0_rvalid), 64'((i % 2) == 1));
      next_cycle();
    end
    p0_req = 1'b0; p1_req = 1'b0;
    at_neg();
    chk("t2_p0_count", 64'(p0_count), 64'd3);
    chk("t2_p1_count", 64'(p1_count), 64'd3);
    chk("t2_p1_rdata", 64'(p1_rdata), 64'h2008_0008);

    // Misaligned read on port 1.
    next_cycle();
    p1_req = 1'b1; p1_addr = 12'h00A;
    at_neg();
    chk("t3_p1_gnt", 64'(p1_gnt), 64'd1);
    next_cycle();
    p1_req = 1'b0;
    at_neg();
    chk("t3_p1_rvalid", 64'(p1_rvalid), 64'd1);
    chk("t3_p1_err", 64'(p1_err), 64'd1);
    chk("t3_p1_rdata", 64'(p1_rdata), 64'd0);
    chk("t3_p1_count", 64'(p1_count), 64'd4);

    // Saturate port 0, then clear coincident with a grant.
    next_cycle();
    p0_req = 1'b1; p0_addr = 12'h008;
    for (int i = 0; i < 17; i++) next_cycle();
    at_neg();
    chk("t4_p0_sat", 64'(p0_count), 64'hF);
    chk("t4_p0_gnt", 64'(p0_gnt), 64'd1);
    next_cycle();
    clr_count = 1'b1;
    next_cycle();
    clr_count = 1'b0; p0_req = 1'b0;
    at_neg();
    chk("t4_p0_clr", 64'(p0_count), 64'd0);
    chk("t4_p1_clr", 64'(p1_count), 64'd0);

    // Grant in the reset cycle produces no response.
    next_cycle();
    p1_req = 1'b1; p1_addr = 12'h00C;
    next_cycle();
    p1_req = 1'b0; p0_req = 1'b1; p0_addr = 12'h014; rst = 1'b1;
    at_neg();
    chk("t5_p0_gnt_rst", 64'(p0_gnt), 64'd1);
    next_cycle();
    rst = 1'b0; p1_req = 1'b1; p1_addr = 12'h018;
    at_neg();
    chk("t5_p0_rvalid", 64'(p0_rvalid), 64'd0);
    chk("t5_p0_count", 64'(p0_count), 64'd0);
    chk("t5_dual_p0_gnt", 64'(p0_gnt), 64'd1);
    next_cycle();
    p0_req = 1'b0; p1_req = 1'b0;
    at_neg();
    chk("t5_p0_rvalid2", 64'(p0_rvalid), 64'd1);
    chk("t5_p0_rdata", 64'(p0_rdata), 64'h2008_0005);

    // Idle: rom_addr follows port 0.
    next_cycle();
    p0_addr = 12'h3FC;
    at_neg();
    chk("t6_rom_addr", 64'(rom_addr), 64'h3FC);
    chk("t6_p0_gnt", 64'(p0_gnt), 64'd0);
    chk("t6_p1_gnt", 64'(p1_gnt), 64'd0);
    next_cycle();
    at_neg();
    chk("t6_p0_rvalid", 64'(p0_rvalid), 64'd0);
    chk("t6_p0_count", 64'(p0_count), 64'd1);

    // Mixed patterns checked by the model only.
    for (int i = 0; i < 24; i++) begin
      next_cycle();
      p0_req = (i % 3) != 0;
      p1_req = (i % 4) != 1;
      p0_addr = 12'(i * 5);
      p1_addr = 12'(i * 12 + 4);
      clr_count = (i == 17);
    end
    next_cycle();
    p0_req = 1'b0; p1_req = 1'b0; clr_count = 1'b0;
    next_cycle();
    at_neg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
